// File: rtl/pipe_run_ctrl.sv
// Run controller for the pipelined core: sequences the core reset, counts run and
// retired-instruction cycles, and ends the run on end-PC, retire stall or timeout.
module pipe_run_ctrl #(
  parameter int              PC_W        = 32,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              STALL_LIMIT = 16,
  parameter logic [PC_W-1:0] END_PC      = 32'h000000FC,
  parameter logic            CPU_RST_ACT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_retire,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             stalled,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int SW = $clog2(STALL_LIMIT) + 1;
  localparam int HW = $clog2(RST_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t          state, next_state;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stall_cnt;
  logic            ev_pass, ev_stall, ev_time;
  logic            start_run;

  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    ev_pass    = 1'b0;
    ev_stall   = 1'b0;
    ev_time    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = HOLD;
          start_run  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) next_state = RUN;
      end
      RUN: begin
        ev_pass  = (cpu_pc == END_PC);
        ev_stall = !cpu_retire && (stall_cnt == STALL_LAST);
        ev_time  = (cycle_cnt == MAX_LAST);
        if (ev_pass || ev_stall || ev_time) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are decoded from next_state so they change with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= CPU_RST_ACT;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      stalled    <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      hold_cnt   <= '0;
      stall_cnt  <= '0;
    end else begin
      state   <= next_state;
      cpu_rst <= (next_state == RUN) ? ~CPU_RST_ACT : CPU_RST_ACT;
      running <= (next_state == RUN);
      done    <= (next_state == DONE);
      if (start_run) begin
        hold_cnt   <= '0;
        stall_cnt  <= '0;
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        pass       <= 1'b0;
        stalled    <= 1'b0;
        timeout    <= 1'b0;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else if (state == RUN) begin
        if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (cpu_retire && (retire_cnt != CNT_MAX)) retire_cnt <= retire_cnt + CNT_W'(1);
        stall_cnt <= cpu_retire ? '0 : stall_cnt + SW'(1);
        // Exactly one reason flag, priority pass > stall > timeout.
        pass    <= ev_pass;
        stalled <= !ev_pass && ev_stall;
        timeout <= !ev_pass && !ev_stall && ev_time;
      end
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: stimulus queues expected end-of-run results,
// a monitor compares them each time done rises.
module tb_pipe_run_ctrl;

  localparam int          RST_CYCLES  = 4;
  localparam int          MAX_CYCLES  = 50;
  localparam int          STALL_LIMIT = 16;
  localparam logic [31:0] END_PC      = 32'h000000FC;

  logic        clk = 1'b0;
  logic        rst, start, cpu_retire;
  logic [31:0] cpu_pc;
  logic        cpu_rst, running, done, pass, stalled, timeout;
  logic [31:0] cycle_cnt, retire_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  flags;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  logic prev_done = 1'b0;

  pipe_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .STALL_LIMIT(STALL_LIMIT), .END_PC(END_PC), .CPU_RST_ACT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cpu_pc(cpu_pc), .cpu_retire(cpu_retire),
    .cpu_rst(cpu_rst), .running(running), .done(done), .pass(pass), .stalled(stalled),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: one queued result per rising edge of done.
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_flags"}, {29'b0, pass, stalled, timeout}, {29'b0, e.flags});
        checkOutput({e.name, "_cycle_cnt"}, cycle_cnt, e.cyc);
        checkOutput({e.name, "_retire_cnt"}, retire_cnt, e.ret);
      end
    end
    prev_done = done;
  end

  task automatic startRun(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_hold_done"}, {31'b0, done}, 32'd0);
    checkOutput({name, "_hold_flags"}, {29'b0, pass, stalled, timeout}, 32'd0);
    checkOutput({name, "_hold_cycle"}, cycle_cnt, 32'd0);
    checkOutput({name, "_hold_retire"}, retire_cnt, 32'd0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      checkOutput({name, "_hold_run_rst"}, {30'b0, running, cpu_rst}, 32'd0);
      @(negedge clk);
    end
    checkOutput({name, "_run_rst"}, {30'b0, running, cpu_rst}, 32'd3);
  endtask

  task automatic applyStimulus(input string name, input logic retire, input int pc_cycle,
                               input logic [2:0] flags, input logic [31:0] cyc, input logic [31:0] ret);
    int k = 0;
    exp_t e;
    e.name = name;
    e.flags = flags;
    e.cyc = cyc;
    e.ret = ret;
    sb.push_back(e);
    while (!done && k < 200) begin
      cpu_retire = retire;
      cpu_pc = (k == pc_cycle) ? END_PC : 32'h100 + 32'(4 * k);
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_wait_done actual=0 expected=1", name);
    end
    cpu_retire = 1'b0;
    cpu_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=expired expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    cpu_retire = 1'b0;
    cpu_pc = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    checkOutput("reset_done_running", {30'b0, done, running}, 32'd0);
    checkOutput("reset_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_rst", {29'b0, running, done, cpu_rst}, 32'd0);

    startRun("first");
    applyStimulus("pass_at_20", 1'b1, 20, 3'b100, 32'd21, 32'd21);
    @(negedge clk);
    checkOutput("done_sticky", {28'b0, done, pass, stalled, timeout}, 32'b1100);

    startRun("restart");
    applyStimulus("stall", 1'b0, -1, 3'b010, 32'd16, 32'd0);

    startRun("from_stall");
    applyStimulus("timeout", 1'b1, -1, 3'b001, 32'd50, 32'd50);

    startRun("from_timeout");
    applyStimulus("pass_over_timeout", 1'b1, 49, 3'b100, 32'd50, 32'd50);

    startRun("from_pass");
    applyStimulus("pass_over_stall", 1'b0, 15, 3'b100, 32'd16, 32'd0);

    // Mid-run start must be ignored; reset at run cycle 10 aborts.
    startRun("abort");
    for (int k = 0; k < 10; k++) begin
      cpu_retire = 1'b1;
      cpu_pc = 32'h100 + 32'(4 * k);
      start = (k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("run_start_ignored_cycle", cycle_cnt, 32'd10);
    checkOutput("run_start_ignored_retire", retire_cnt, 32'd10);
    checkOutput("run_start_ignored_running", {31'b0, running}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cpu_retire = 1'b0;
    checkOutput("abort_status", {26'b0, cpu_rst, running, done, pass, stalled, timeout}, 32'd0);
    checkOutput("abort_cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("abort_retire_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    checkOutput("abort_stays_idle", {30'b0, running, cpu_rst}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
